// File: rtl/uart_tx_bps_if.sv
// Byte-in / serial-out bundle between the readback stream controller and the UART transmitter.
// The controller owns txd_en/txd_data; the transmitter owns the tick, line and status outputs.
interface uart_tx_bps_if;
  logic       txd_en;
  logic [7:0] txd_data;
  logic       clk_bps;
  logic       txd;
  logic       tx_busy;
  logic       txd_done;
  logic       tx_overrun;

  modport master (
    output txd_en, txd_data,
    input  clk_bps, txd, tx_busy, txd_done, tx_overrun
  );

  modport slave (
    input  txd_en, txd_data,
    output clk_bps, txd, tx_busy, txd_done, tx_overrun
  );
endinterface

// File: rtl/uart_tx_bps.sv
// UART transmitter with a free-running baud tick: 1 start, 8 data (LSB first),
// optional parity, 1 stop. Every output is a flop; the FSM advances only on the registered tick.
module uart_tx_bps #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600,
  parameter int PARITY   = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  uart_tx_bps_if.slave bus
);

  localparam int          BPS_DIV  = CLK_FREQ / BAUD;
  localparam logic [15:0] BPS_LAST = 16'(BPS_DIV - 1);
  localparam bit          PAR_EN   = (PARITY == 1) || (PARITY == 2);
  localparam bit          PAR_ODD  = (PARITY == 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT, ST_START, ST_DATA, ST_PAR, ST_STOP
  } state_t;

  logic [15:0] cnt_q, cnt_d;
  logic        clk_bps_q, clk_bps_d;
  state_t      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        par_q, par_d;
  logic        txd_q, txd_d;
  logic        tx_busy_q, tx_busy_d;
  logic        txd_done_q, txd_done_d;
  logic        tx_overrun_q, tx_overrun_d;

  // Baud generator runs regardless of FSM state so the upstream controller keeps its pacing.
  always_comb begin
    cnt_d     = cnt_q + 16'd1;
    clk_bps_d = 1'b0;
    if (cnt_q == BPS_LAST) begin
      cnt_d     = '0;
      clk_bps_d = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    par_d        = par_q;
    txd_d        = txd_q;
    txd_done_d   = 1'b0;
    tx_overrun_d = bus.txd_en && (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        txd_d = 1'b1;
        if (bus.txd_en) begin
          shift_d = bus.txd_data;
          par_d   = PAR_ODD ? ~^bus.txd_data : ^bus.txd_data;
          state_d = ST_WAIT;
        end
      end
      // A tick seen in the accept cycle belongs to IDLE, so only a later tick starts the frame.
      ST_WAIT: begin
        if (clk_bps_q) begin
          txd_d   = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (clk_bps_q) begin
          txd_d     = shift_q[0];
          bit_cnt_d = 3'd0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (clk_bps_q) begin
          if (bit_cnt_q == 3'd7) begin
            if (PAR_EN) begin
              txd_d   = par_q;
              state_d = ST_PAR;
            end else begin
              txd_d   = 1'b1;
              state_d = ST_STOP;
            end
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            txd_d     = shift_q[1];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      ST_PAR: begin
        if (clk_bps_q) begin
          txd_d   = 1'b1;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (clk_bps_q) begin
          txd_done_d = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = ST_IDLE;
      end
    endcase

    tx_busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      clk_bps_q    <= 1'b0;
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      par_q        <= 1'b0;
      txd_q        <= 1'b1;
      tx_busy_q    <= 1'b0;
      txd_done_q   <= 1'b0;
      tx_overrun_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      clk_bps_q    <= clk_bps_d;
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      par_q        <= par_d;
      txd_q        <= txd_d;
      tx_busy_q    <= tx_busy_d;
      txd_done_q   <= txd_done_d;
      tx_overrun_q <= tx_overrun_d;
    end
  end

  assign bus.clk_bps    = clk_bps_q;
  assign bus.txd        = txd_q;
  assign bus.tx_busy    = tx_busy_q;
  assign bus.txd_done   = txd_done_q;
  assign bus.tx_overrun = tx_overrun_q;

endmodule

// File: doc/uart_tx_bps.md
Name: uart_tx_bps

Overview:
- Serial back end of the SDRAM-to-UART readback path.
- Generates the free-running baud tick clk_bps that paces the upstream read-stream controller.
- Accepts one byte per txd_en strobe from that controller and shifts it out on txd as an asynchronous frame: 1 start bit, 8 data bits LSB first, optional parity, 1 stop bit.
- Reports busy, frame-done and dropped-byte status.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz.
BAUD, 9600, serial bit rate; BPS_DIV = CLK_FREQ/BAUD (integer division, truncated); legal range 2..65535.
PARITY, 0, 0 = none, 1 = odd, 2 = even; values 3 and above behave as 0.

Ports:
clk  input  1  system clock.
rst_n  input  1  asynchronous active-low reset.
txd_en  input  1  one-cycle byte strobe; txd_data is valid in the same cycle.
txd_data  input  8  byte to transmit.
clk_bps  output  1  one-cycle baud tick, period BPS_DIV clocks.
txd  output  1  serial line, idles high.
tx_busy  output  1  high from the accept cycle+1 until the frame completes.
txd_done  output  1  one-cycle pulse at the end of the stop bit.
tx_overrun  output  1  one-cycle pulse when txd_en arrives while busy.

Behaviour:
- Interface decisions: reset rst_n, asynchronous, active-low; clock clk.
- Reset values: clk_bps=0, txd=1, tx_busy=0, txd_done=0, tx_overrun=0. The 16-bit baud counter resets to 0, the FSM to IDLE, and the shift register to 0.
- All outputs are registered.
- Baud counter:
  - Increments every cycle.
  - When count==BPS_DIV-1 it wraps to 0, and clk_bps goes high the following cycle for exactly one cycle.
  - Free-running; independent of the FSM.
  - First clk_bps is high in cycle BPS_DIV after reset release (cycles counted from 0).
- FSM states: IDLE, WAIT, START, DATA, PAR, STOP.
- IDLE:
  - txd=1.
  - txd_en=1 latches txd_data into the shift register.
  - Parity is computed from the latched byte: even = XOR of bits; odd = inverted XOR.
  - Next state is WAIT; tx_busy=1 from the next cycle.
- WAIT: on the first clk_bps strictly after the accept cycle, drive txd=0 from the next cycle and go to START. A clk_bps coincident with the accept cycle is ignored.
- START: on clk_bps, drive txd=shift[0], clear the bit counter, go to DATA.
- DATA:
  - Each clk_bps shifts right and increments the bit counter (3 bits).
  - After bit 7 has been held for one full period: go to PAR (if PARITY is 1 or 2) or to STOP, with txd=parity or txd=1 respectively.
- PAR: on clk_bps, txd=1, go to STOP.
- STOP: on clk_bps, go to IDLE. Same edge: txd_done=1 for one cycle and tx_busy=0.
- Frame length is 10 bps periods without parity, 11 with parity; each bit is held exactly BPS_DIV clocks.
- txd_en in IDLE is accepted in the same cycle the FSM enters IDLE from STOP. This gives back-to-back frames; only the WAIT gap (up to one period) separates them.
- txd_en while the FSM is not in IDLE:
  - The byte is dropped and tx_overrun pulses the next cycle.
  - The frame in flight is unaffected.
  - tx_busy is defined as FSM != IDLE, registered.
- txd_data is sampled only in the accept cycle; later changes have no effect.
- rst_n asserted mid-frame: immediate return to reset values, with txd=1 asynchronously. No partial frame resumes after release.

Test Plan:
- CLK_FREQ=1600, BAUD=100 (BPS_DIV=16); release reset -> clk_bps first high at cycle 16, then every 16 cycles; txd stays 1, tx_busy stays 0.
- PARITY=0; txd_en with 0xA5 two cycles after a tick:
  - txd low at the next tick+1, then bits 1,0,1,0,0,1,0,1, then stop=1, each 16 clocks.
  - txd_done pulses at the tick ending the stop bit; 160 clocks from start to done.
- PARITY=2 with 0x07 -> parity bit=1; PARITY=1 with 0x07 -> parity bit=0. Frame is 176 clocks; txd_done follows the stop bit.
- txd_en pulses every 9 cycles for 3 bytes during a frame -> first byte sent; tx_overrun pulses for bytes 2 and 3; no corruption of the first frame.
- txd_en asserted in the cycle the FSM re-enters IDLE after txd_done -> accepted; second frame starts at the next tick; no overrun pulse.
- rst_n low during data bit 4 -> txd=1 and tx_busy=0 immediately; after release, the line stays idle until a new txd_en.
